// File: rtl/feature_quant_packer_pkg.sv
// -----------------------------------------------------------------------------
// feature_quant_packer_pkg
// Shared definitions for the LogicNets input stage and the layer-0 neurons:
//   - default parameter values (code width, feature count, raw width, counter)
//   - threshold-address field helpers ({feature index, threshold index k})
//   - reset-time threshold function (uniform bins over the raw range)
//   - classification of a feature accept with respect to sample length
// Bit ordering shared with the neurons: feature i occupies bits
// [i*QBITS +: QBITS] of the packed vector.
// -----------------------------------------------------------------------------
package feature_quant_packer_pkg;

  localparam int QBITS_DEF        = 2;
  localparam int NUM_FEATURES_DEF = 16;
  localparam int FEAT_W_DEF       = 16;
  localparam int CNT_W_DEF        = 16;

  // Number of thresholds per feature for a given code width.
  function automatic int num_thresh(input int qbits);
    return (1 << qbits) - 1;
  endfunction

  // Width of the feature-index field of the threshold address.
  // A single-feature configuration still gets a 1-bit field.
  function automatic int fidx_w(input int num_features);
    return (num_features > 1) ? $clog2(num_features) : 1;
  endfunction

  // Reset value of threshold k: (k+1) << (FEAT_W-QBITS), i.e. the raw range
  // split into 2^QBITS equal bins. Caller truncates to FEAT_W.
  function automatic logic [63:0] default_thresh(input int feat_w, input int qbits,
                                                 input int k);
    return 64'(k + 1) << (feat_w - qbits);
  endfunction

  // What a single feature accept means for the sample being assembled.
  typedef enum logic [1:0] {
    EVT_NONE = 2'd0,  // no accept this cycle
    EVT_MID  = 2'd1,  // interior feature, keep assembling
    EVT_DONE = 2'd2,  // last feature at the last index: vector complete
    EVT_ERR  = 2'd3   // length mismatch: drop the partial sample
  } accept_evt_e;

endpackage

// File: rtl/feature_quantizer.sv
// -----------------------------------------------------------------------------
// feature_quantizer
// Purely combinational: maps one raw feature value onto a QBITS code by
// counting how many thresholds of the selected feature it meets or exceeds.
// Thresholds need not be monotonic; each one is counted independently.
// Ports:
//   value_i       raw unsigned feature value
//   thresh_row_i  2^QBITS-1 thresholds, threshold k at [k*FEAT_W +: FEAT_W]
//   code_o        number of thresholds with value_i >= threshold
// -----------------------------------------------------------------------------
module feature_quantizer
  import feature_quant_packer_pkg::*;
#(
  parameter int  FEAT_W = FEAT_W_DEF,
  parameter int  QBITS  = QBITS_DEF,
  localparam int NT     = num_thresh(QBITS)
) (
  input  logic [FEAT_W-1:0]    value_i,
  input  logic [NT*FEAT_W-1:0] thresh_row_i,
  output logic [QBITS-1:0]     code_o
);

  logic [NT-1:0] ge;

  generate
    for (genvar gi = 0; gi < NT; gi++) begin : g_cmp
      assign ge[gi] = (value_i >= thresh_row_i[gi*FEAT_W +: FEAT_W]);
    end
  endgenerate

  // Population count of the compare results; at most NT, which fits QBITS.
  always_comb begin
    code_o = '0;
    for (int k = 0; k < NT; k++) begin
      code_o = code_o + QBITS'(ge[k]);
    end
  end

endmodule

// File: rtl/feature_quant_packer.sv
// -----------------------------------------------------------------------------
// feature_quant_packer
// Input stage of the binary-classification LogicNets datapath. Takes one raw
// feature per handshake, quantizes it against programmable per-feature
// thresholds, assembles the codes of one sample into a flat vector and hands
// the vector downstream over valid/ready. A hold buffer behind the output
// register lets assembly of the next sample overlap a downstream stall.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready   raw feature stream handshake
//   s_data, s_last    raw feature value, marks final feature of a sample
//   m_valid/m_ready   packed vector handshake
//   m_data            packed codes, feature i at [i*QBITS +: QBITS]
//   cfg_we/addr/data  threshold write, addr = {feature index, k}
//   err_len           sticky flag: a sample of the wrong length was seen
//   sample_cnt        vectors accepted downstream, wrapping
// -----------------------------------------------------------------------------
module feature_quant_packer
  import feature_quant_packer_pkg::*;
#(
  parameter int  NUM_FEATURES = NUM_FEATURES_DEF,
  parameter int  FEAT_W       = FEAT_W_DEF,
  parameter int  QBITS        = QBITS_DEF,
  parameter int  CNT_W        = CNT_W_DEF,
  localparam int NT           = num_thresh(QBITS),
  localparam int FIDX_W       = fidx_w(NUM_FEATURES),
  localparam int ADDR_W       = FIDX_W + QBITS,
  localparam int VEC_W        = NUM_FEATURES * QBITS,
  localparam int ROW_W        = NT * FEAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [FEAT_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [VEC_W-1:0]  m_data,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [FEAT_W-1:0] cfg_data,
  output logic              err_len,
  output logic [CNT_W-1:0]  sample_cnt
);

  localparam logic [FIDX_W-1:0] LAST_IDX = FIDX_W'(NUM_FEATURES - 1);

  // ---------------------------------------------------------------------------
  // Threshold table
  // ---------------------------------------------------------------------------
  logic [FIDX_W-1:0] cfg_f;
  logic [QBITS-1:0]  cfg_k;
  logic [FEAT_W-1:0] thr_q  [NUM_FEATURES][NT];
  logic              we_hit [NUM_FEATURES][NT];

  assign cfg_f = cfg_addr[ADDR_W-1:QBITS];
  assign cfg_k = cfg_addr[QBITS-1:0];

  // Only addresses that name an existing threshold produce a hit, so writes
  // with k = 2^QBITS-1 or an out-of-range feature index fall through silently.
  generate
    for (genvar gi = 0; gi < NUM_FEATURES; gi++) begin : g_feat
      for (genvar gk = 0; gk < NT; gk++) begin : g_thr
        assign we_hit[gi][gk] = cfg_we && (cfg_f == FIDX_W'(gi)) && (cfg_k == QBITS'(gk));
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < NUM_FEATURES; f++) begin
        for (int k = 0; k < NT; k++) begin
          thr_q[f][k] <= FEAT_W'(default_thresh(FEAT_W, QBITS, k));
        end
      end
    end else begin
      for (int f = 0; f < NUM_FEATURES; f++) begin
        for (int k = 0; k < NT; k++) begin
          if (we_hit[f][k]) begin
            thr_q[f][k] <= cfg_data;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Quantization of the current feature
  // ---------------------------------------------------------------------------
  logic [FIDX_W-1:0] index_q;
  logic [ROW_W-1:0]  cur_row;
  logic [QBITS-1:0]  code;

  // The table is read from registers, so a write on the accept edge is not
  // yet visible: the accept uses the old value.
  always_comb begin
    cur_row = '0;
    for (int f = 0; f < NUM_FEATURES; f++) begin
      if (index_q == FIDX_W'(f)) begin
        for (int k = 0; k < NT; k++) begin
          cur_row[k*FEAT_W +: FEAT_W] = thr_q[f][k];
        end
      end
    end
  end

  feature_quantizer #(
    .FEAT_W (FEAT_W),
    .QBITS  (QBITS)
  ) u_quantizer (
    .value_i      (s_data),
    .thresh_row_i (cur_row),
    .code_o       (code)
  );

  // ---------------------------------------------------------------------------
  // Assembly, output register, hold buffer, counters
  // ---------------------------------------------------------------------------
  logic [VEC_W-1:0] asm_q;
  logic [VEC_W-1:0] asm_d;
  logic [VEC_W-1:0] out_q;
  logic [VEC_W-1:0] hold_q;
  logic             m_valid_q;
  logic             hold_full_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             out_fire;
  accept_evt_e      evt;

  assign s_ready    = !hold_full_q;
  assign accept     = s_valid && s_ready;
  assign out_fire   = m_valid_q && m_ready;
  assign m_valid    = m_valid_q;
  assign m_data     = out_q;
  assign err_len    = err_q;
  assign sample_cnt = cnt_q;

  // Assembly buffer with the current code dropped into its slot; on the last
  // feature this is the complete vector.
  always_comb begin
    asm_d = asm_q;
    for (int f = 0; f < NUM_FEATURES; f++) begin
      if (index_q == FIDX_W'(f)) begin
        asm_d[f*QBITS +: QBITS] = code;
      end
    end
  end

  always_comb begin
    evt = EVT_NONE;
    if (accept) begin
      if (index_q == LAST_IDX) begin
        evt = s_last ? EVT_DONE : EVT_ERR;
      end else begin
        evt = s_last ? EVT_ERR : EVT_MID;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q     <= '0;
      asm_q       <= '0;
      out_q       <= '0;
      hold_q      <= '0;
      m_valid_q   <= 1'b0;
      hold_full_q <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      // Stale slots of a dropped sample need no clearing: every slot is
      // rewritten before the next completion.
      if (accept) begin
        asm_q <= asm_d;
      end

      case (evt)
        EVT_MID:  index_q <= index_q + 1'b1;
        EVT_DONE: index_q <= '0;
        EVT_ERR:  index_q <= '0;
        default:  index_q <= index_q;
      endcase

      if (evt == EVT_ERR) begin
        err_q <= 1'b1;
      end

      if (out_fire) begin
        cnt_q <= cnt_q + 1'b1;
      end

      // A completion can only coincide with a full hold buffer if s_ready
      // were high, which it is not, so these cases are exclusive.
      if (out_fire) begin
        if (hold_full_q) begin
          out_q       <= hold_q;
          hold_full_q <= 1'b0;
        end else if (evt == EVT_DONE) begin
          out_q <= asm_d;
        end else begin
          m_valid_q <= 1'b0;
        end
      end else if (evt == EVT_DONE) begin
        if (!m_valid_q) begin
          out_q     <= asm_d;
          m_valid_q <= 1'b1;
        end else begin
          hold_q      <= asm_d;
          hold_full_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/feature_quant_packer.md
Name: feature_quant_packer

Overview:
Input stage of the binary-classification LogicNets datapath; sits directly upstream of the layer-0 neuron LUTs.
- Accepts one raw feature word per handshake from the feature-extraction stream.
- Quantizes each word to QBITS against per-feature programmable thresholds.
- Assembles the codes of one sample into a flat input vector and presents it downstream over valid/ready.
- Double-buffers, so assembly of sample n+1 overlaps the downstream stall of sample n.

Parameters:
NUM_FEATURES, 16, features per sample (vector width = NUM_FEATURES*QBITS)
FEAT_W, 16, raw feature width, unsigned
QBITS, 2, code width; 2^QBITS-1 thresholds per feature
CNT_W, 16, sample counter width

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  raw feature valid
s_ready  out  1  raw feature ready
s_data  in  FEAT_W  raw feature value
s_last  in  1  marks final feature of a sample
m_valid  out  1  packed vector valid
m_ready  in  1  downstream ready
m_data  out  NUM_FEATURES*QBITS  packed codes; feature i at bits [i*QBITS +: QBITS]
cfg_we  in  1  threshold write strobe
cfg_addr  in  $clog2(NUM_FEATURES)+QBITS  {feature index, threshold index k}
cfg_data  in  FEAT_W  threshold value
err_len  out  1  sticky: sample length mismatch seen
sample_cnt  out  CNT_W  number of vectors accepted downstream, wraps

Behaviour:
- Reset (async assert, sync release): m_valid=0, m_data=0, err_len=0, sample_cnt=0, index=0, hold buffer empty, s_ready=1.
- Reset threshold T[f][k] = (k+1) << (FEAT_W-QBITS) (uniform bins).
- Quantization: code = number of k in 0..2^QBITS-2 with s_data >= T[f][k], where f = current index. Unsigned compare. Non-monotonic thresholds are still counted as defined; no check.
- The code is written into the assembly buffer on the accept edge (s_valid & s_ready). index increments on each accept.
- Normal completion: s_last accepted at index NUM_FEATURES-1. The full vector goes to the output register if m_valid=0 or (m_valid & m_ready) on that edge; m_valid=1 the next cycle (latency 1 from last accept). Otherwise the vector goes to the hold buffer and index returns to 0.
- s_ready = !(hold buffer full). While hold is full, the next sample cannot start.
- On an output handshake, the hold buffer (if full) moves to the output register on the same edge; m_valid stays 1 and s_ready rises next cycle.
- A simultaneous output handshake and last-feature accept with hold empty loads the new vector straight into the output register.
- m_data is stable while m_valid & !m_ready.
- sample_cnt increments on each m_valid & m_ready; wraps 2^CNT_W-1 -> 0.
- Length errors, both of which set err_len, discard the partial sample, reset index to 0 and leave outputs untouched:
  - s_last accepted at index < NUM_FEATURES-1.
  - index NUM_FEATURES-1 accepted without s_last.
- err_len clears only on reset.
- Config: a write to T[f][k] takes effect for accepts on later cycles; a same-cycle accept uses the old value. Writes with k = 2^QBITS-1 or f >= NUM_FEATURES are ignored.
- Reset mid-sample or mid-stall drops all buffered data.

Decomposition:
- Shared package: QBITS, NUM_FEATURES defaults, FEAT_W, the threshold-address field split, and the default-threshold function. The layer-0 neuron modules use the same QBITS and bit ordering.
- One sub-module: feature_quantizer. It is combinational: raw value plus the threshold row for the selected feature in, QBITS code out.
- Counter, buffers and handshake stay in the top.

Test Plan:
- Reset defaults, NUM_FEATURES=3, FEAT_W=16: stream 0x0000, 0x4000, 0xFFFF with last on the third, m_ready=1 -> m_valid one cycle after the last accept, m_data=6'b11_01_00, sample_cnt=1.
- Program T[1][0]=0x0100 and T[1][1]=0x0200 (T[1][2] stays at reset value 0xC000), then stream 0, 0x0150, 0 -> m_data=6'b00_01_00.
- Backpressure: m_ready=0, send two samples -> s_ready drops after the second last-accept and the first vector stays stable. Raise m_ready -> both vectors are delivered in order, s_ready returns, sample_cnt=2.
- s_last on the 2nd feature -> err_len=1, no m_valid. The next correct sample is delivered normally.
- Assert rst_n=0 after 2 features of a sample -> all outputs return to reset values. A fresh 3-feature sample is then delivered correctly.
- cfg_we on the same edge as a feature accept -> the code uses the old threshold; the next sample uses the new one.
